bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester (CPU/DMA) external memory bus arbiter with RAM/ROM chip selects
// Optional round-robin tie-break: define ARB_ROUND_ROBIN_EN; default build uses fixed CPU priority.
module bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_write,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    input  logic        i_dma_req,
    input  logic        i_dma_write,
    input  logic [15:0] i_dma_address,
    input  logic [7:0]  i_dma_wdata,
    output logic        o_dma_ack,
    output logic [7:0]  o_rdata,
    output logic [15:0] o_address_bus,
    output logic        o_ram_enable,
    output logic        o_rom_enable,
    output logic        o_write,
    output logic        o_write_bar,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    input  logic [7:0]  i_data_in,
    output logic        o_busy
);

    localparam logic [2:0] LP_LAST_WAIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_wait_cnt;
    logic        r_last_dma;
    logic        r_write;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;

    logic w_any_req;
    logic w_grant_dma;
    logic w_enable;
    logic w_strobe;
    logic w_capture;
    logic w_cpu_ack;
    logic w_dma_ack;

    assign w_any_req = i_cpu_req | i_dma_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the requester that did not win last time gets the bus.
    assign w_grant_dma = i_dma_req & (~i_cpu_req | ~r_last_dma);
`else
    assign w_grant_dma = i_dma_req & ~i_cpu_req;
`endif

    always_comb begin
        w_next_state = r_state;
        w_enable     = 1'b0;
        w_strobe     = 1'b0;
        w_capture    = 1'b0;
        w_cpu_ack    = 1'b0;
        w_dma_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_enable     = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_enable = 1'b1;
                // ROM is never strobed; a ROM write simply completes as a no-op.
                w_strobe = r_write & r_addr[15];
                if (r_wait_cnt == LP_LAST_WAIT) begin
                    w_capture    = ~r_write;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_cpu_ack    = ~r_last_dma;
                w_dma_ack    = r_last_dma;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
            r_last_dma <= 1'b1;
            r_write    <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 8'h00;
            r_rdata    <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_any_req) begin
                r_last_dma <= w_grant_dma;
                r_write    <= w_grant_dma ? i_dma_write   : i_cpu_write;
                r_addr     <= w_grant_dma ? i_dma_address : i_cpu_address;
                r_wdata    <= w_grant_dma ? i_dma_wdata   : i_cpu_wdata;
            end
            if (r_state == ST_ACCESS && r_wait_cnt != LP_LAST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end else begin
                r_wait_cnt <= 3'd0;
            end
            if (w_capture) begin
                r_rdata <= i_data_in;
            end
        end
    end

    assign o_cpu_ack     = w_cpu_ack;
    assign o_dma_ack     = w_dma_ack;
    assign o_rdata       = r_rdata;
    assign o_address_bus = r_addr;
    assign o_ram_enable  = w_enable & r_addr[15];
    assign o_rom_enable  = w_enable & ~r_addr[15];
    assign o_write       = w_strobe;
    assign o_write_bar   = ~w_strobe;
    assign o_data_oe     = w_strobe;
    assign o_data_out    = w_strobe ? r_wdata : 8'h00;
    assign o_busy        = (r_state != ST_IDLE);

endmodule
